mem_wb_skid_buffer: RTL and testbench

Parametrised MEM→WB pipeline register with valid/ready flow control, a 2-entry skid stage and synchronous flush. It carries a configurable number of register-write channels, for example GPR plus HI/LO, from the memory stage to write-back. It sits between the MEM stage and the register-file write ports. Back-pressure from write-back, such as a port conflict or a multi-cycle HI/LO write, never drops or duplicates a result.

---
 rtl/mem_wb_skid_buffer_if.sv | 45 ++++
 rtl/mem_wb_skid_buffer.sv | 138 +++++++++++++
 tb/tb_mem_wb_skid_buffer.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/mem_wb_skid_buffer_if.sv
// rtl/mem_wb_skid_buffer_if.sv - MEM->WB handshake bundle for the skid buffer
//
// Purpose: groups the MEM-side entry handshake, WB-side entry handshake,
//          flush and occupancy of mem_wb_skid_buffer.
// Ports (signals):
//   in_valid / in_ready                        MEM presents / buffer accepts
//   in_write_enable/addr/data                  per-channel payload from MEM
//   flush                                      synchronous discard
//   out_valid / out_ready                      buffer presents / WB consumes
//   out_write_enable/addr/data                 per-channel payload to WB
//   occupancy                                  held entries, 0..2
// Modports: slave = buffer view, master = MEM/WB (driver) view.

interface mem_wb_skid_buffer_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned CHANNELS   = 2
);
  logic                           in_valid;
  logic                           in_ready;
  logic [CHANNELS-1:0]            in_write_enable;
  logic [CHANNELS*ADDR_WIDTH-1:0] in_write_addr;
  logic [CHANNELS*DATA_WIDTH-1:0] in_write_data;
  logic                           flush;
  logic                           out_valid;
  logic                           out_ready;
  logic [CHANNELS-1:0]            out_write_enable;
  logic [CHANNELS*ADDR_WIDTH-1:0] out_write_addr;
  logic [CHANNELS*DATA_WIDTH-1:0] out_write_data;
  logic [1:0]                     occupancy;

  modport slave (
    input  in_valid, in_write_enable, in_write_addr, in_write_data,
    input  flush, out_ready,
    output in_ready, out_valid, out_write_enable, out_write_addr,
    output out_write_data, occupancy
  );

  modport master (
    output in_valid, in_write_enable, in_write_addr, in_write_data,
    output flush, out_ready,
    input  in_ready, out_valid, out_write_enable, out_write_addr,
    input  out_write_data, occupancy
  );
endinterface

// File: rtl/mem_wb_skid_buffer.sv
// rtl/mem_wb_skid_buffer.sv - MEM->WB pipeline register with 2-entry skid and flush
//
// Purpose: carries CHANNELS register-write channels from MEM to WB with
//          valid/ready flow control; never drops or duplicates an entry.
// Ports:
//   clock  rising-edge clock
//   reset  asynchronous active-low reset
//   bus    mem_wb_skid_buffer_if.slave (handshakes, payloads, flush, occupancy)

module mem_wb_skid_buffer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned CHANNELS   = 2,
  parameter int unsigned NOP_ADDR   = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  mem_wb_skid_buffer_if.slave   bus
);

  localparam int unsigned AW = CHANNELS * ADDR_WIDTH;
  localparam int unsigned DW = CHANNELS * DATA_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] NOP = ADDR_WIDTH'(NOP_ADDR);

  logic                main_valid_q, main_valid_d;
  logic [CHANNELS-1:0] main_en_q,    main_en_d;
  logic [AW-1:0]       main_addr_q,  main_addr_d;
  logic [DW-1:0]       main_data_q,  main_data_d;
  logic                skid_valid_q, skid_valid_d;
  logic [CHANNELS-1:0] skid_en_q,    skid_en_d;
  logic [AW-1:0]       skid_addr_q,  skid_addr_d;
  logic [DW-1:0]       skid_data_q,  skid_data_d;

  logic [AW-1:0]       cap_addr;
  logic [DW-1:0]       cap_data;
  logic                accept;
  logic                drain;

  // in_ready comes straight from the skid flop, so out_ready never reaches it.
  assign bus.in_ready = ~skid_valid_q;
  assign accept       = bus.in_valid & ~skid_valid_q;
  assign drain        = main_valid_q & bus.out_ready;

  // Disabled channels are normalised on capture so the held payload is already
  // in its idle form and the output mux only has to handle !main_valid.
  always_comb begin
    cap_addr = '0;
    cap_data = '0;
    for (int c = 0; c < int'(CHANNELS); c++) begin
      if (bus.in_write_enable[c]) begin
        cap_addr[c*ADDR_WIDTH +: ADDR_WIDTH] = bus.in_write_addr[c*ADDR_WIDTH +: ADDR_WIDTH];
        cap_data[c*DATA_WIDTH +: DATA_WIDTH] = bus.in_write_data[c*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        cap_addr[c*ADDR_WIDTH +: ADDR_WIDTH] = NOP;
      end
    end
  end

  always_comb begin
    main_valid_d = main_valid_q;
    main_en_d    = main_en_q;
    main_addr_d  = main_addr_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_en_d    = skid_en_q;
    skid_addr_d  = skid_addr_q;
    skid_data_d  = skid_data_q;

    if (bus.flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q) begin
      if (accept) begin
        main_valid_d = 1'b1;
        main_en_d    = bus.in_write_enable;
        main_addr_d  = cap_addr;
        main_data_d  = cap_data;
      end
    end else if (drain) begin
      if (skid_valid_q) begin
        // in_ready is low while skid is full, so no accept competes here.
        main_en_d    = skid_en_q;
        main_addr_d  = skid_addr_q;
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_en_d    = bus.in_write_enable;
        main_addr_d  = cap_addr;
        main_data_d  = cap_data;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_en_d    = bus.in_write_enable;
      skid_addr_d  = cap_addr;
      skid_data_d  = cap_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      main_valid_q <= 1'b0;
      main_en_q    <= '0;
      main_addr_q  <= '0;
      main_data_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_en_q    <= '0;
      skid_addr_q  <= '0;
      skid_data_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_en_q    <= main_en_d;
      main_addr_q  <= main_addr_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_en_q    <= skid_en_d;
      skid_addr_q  <= skid_addr_d;
      skid_data_q  <= skid_data_d;
    end
  end

  // Gated purely from flops, so reset forces the idle values without an edge.
  always_comb begin
    bus.out_valid        = main_valid_q;
    bus.out_write_enable = '0;
    bus.out_write_addr   = {CHANNELS{NOP}};
    bus.out_write_data   = '0;
    if (main_valid_q) begin
      bus.out_write_enable = main_en_q;
      bus.out_write_addr   = main_addr_q;
      bus.out_write_data   = main_data_q;
    end
  end

  assign bus.occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

endmodule

// File: tb/tb_mem_wb_skid_buffer.sv
// tb/tb_mem_wb_skid_buffer.sv - scoreboard bench for mem_wb_skid_buffer

module tb_mem_wb_skid_buffer;

  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int CH  = 2;
  localparam int NOP = 30;
  localparam logic [4:0] NOP_A     = 5'd30;
  localparam logic [9:0] IDLE_ADDR = {NOP_A, NOP_A};

  typedef struct packed {
    logic [1:0]  en;
    logic [9:0]  addr;
    logic [63:0] data;
  } entry_t;

  logic   clock = 1'b0;
  logic   reset = 1'b0;
  entry_t exp_q[$];
  int     held = 0;
  int     n_cmp = 0;
  int     n_bad = 0;

  always #5 clock = ~clock;

  mem_wb_skid_buffer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CHANNELS(CH)) bus ();

  mem_wb_skid_buffer #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CHANNELS(CH), .NOP_ADDR(NOP)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // What WB must see for an entry: disabled channels read as NOP address, zero data.
  function automatic entry_t mk(input logic [1:0] en, input logic [9:0] addr, input logic [63:0] data);
    entry_t e;
    e.en = en;
    for (int c = 0; c < 2; c++) begin
      e.addr[c*5 +: 5]   = en[c] ? addr[c*5 +: 5] : NOP_A;
      e.data[c*32 +: 32] = en[c] ? data[c*32 +: 32] : 32'h0;
    end
    return e;
  endfunction

  // Reference model: the buffer is a FIFO of depth 2; accepting is allowed
  // whenever fewer than 2 entries are held; flush empties it.
  task automatic cycle(input logic iv, input logic [1:0] en, input logic [9:0] addr,
                       input logic [63:0] data, input logic fl, input logic ordy);
    bit acc, drn;
    bus.in_valid        = iv;
    bus.in_write_enable = en;
    bus.in_write_addr   = addr;
    bus.in_write_data   = data;
    bus.flush           = fl;
    bus.out_ready       = ordy;
    @(posedge clock);
    if (reset) begin
      acc = iv && (held < 2);
      drn = (held > 0) && ordy;
      if (fl) begin
        held = 0;
        exp_q.delete();
      end else begin
        held = held - int'(drn) + int'(acc);
        if (acc) exp_q.push_back(mk(en, addr, data));
      end
    end
    #1;
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, 2'b00, 10'h0, 64'h0, 1'b0, ordy);
  endtask

  // Monitor: compares whatever the DUT presents against the model's queue.
  always @(negedge clock) begin
    chk("occupancy", 64'(bus.occupancy), 64'(held));
    chk("in_ready", 64'(bus.in_ready), 64'(held < 2));
    chk("out_valid", 64'(bus.out_valid), 64'(held > 0));
    if (held > 0 && exp_q.size() > 0) begin
      chk("out_en", 64'(bus.out_write_enable), 64'(exp_q[0].en));
      chk("out_addr", 64'(bus.out_write_addr), 64'(exp_q[0].addr));
      chk("out_data", bus.out_write_data, exp_q[0].data);
      if (bus.out_ready) void'(exp_q.pop_front());
    end else begin
      chk("idle_en", 64'(bus.out_write_enable), 64'h0);
      chk("idle_addr", 64'(bus.out_write_addr), 64'(IDLE_ADDR));
      chk("idle_data", bus.out_write_data, 64'h0);
    end
  end

  initial begin
    logic [63:0] rd;
    bus.in_valid = 1'b0; bus.in_write_enable = '0; bus.in_write_addr = '0;
    bus.in_write_data = '0; bus.flush = 1'b0; bus.out_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'h1);
    chk("rst_occupancy", 64'(bus.occupancy), 64'h0);
    reset = 1'b1;

    // Streaming, 4 back-to-back entries
    for (int i = 1; i <= 4; i++)
      cycle(1'b1, 2'b11, {5'(i + 8), 5'(i)}, {32'(i * 3), 32'(i * 17)}, 1'b0, 1'b1);
    idle(1'b1);

    // Back-pressure: A, B fill, C refused, then A, B, C drain in order
    cycle(1'b1, 2'b01, {5'd0, 5'd3}, 64'hA, 1'b0, 1'b0);
    cycle(1'b1, 2'b01, {5'd0, 5'd4}, 64'hB, 1'b0, 1'b0);
    chk("bp_occupancy", 64'(bus.occupancy), 64'h2);
    chk("bp_in_ready", 64'(bus.in_ready), 64'h0);
    cycle(1'b1, 2'b01, {5'd0, 5'd5}, 64'hC, 1'b0, 1'b0);
    cycle(1'b1, 2'b01, {5'd0, 5'd5}, 64'hC, 1'b0, 1'b1);
    cycle(1'b1, 2'b01, {5'd0, 5'd5}, 64'hC, 1'b0, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Disabled channel 1
    cycle(1'b1, 2'b01, {5'd7, 5'd9}, {32'hDEAD, 32'h1234}, 1'b0, 1'b0);
    rd = 64'(bus.out_write_addr);
    chk("dis_ch1_addr", 64'(rd[9:5]), 64'(NOP_A));
    chk("dis_ch0_addr", 64'(rd[4:0]), 64'd9);
    rd = bus.out_write_data;
    chk("dis_ch1_data", 64'(rd[63:32]), 64'h0);
    chk("dis_ch0_data", 64'(rd[31:0]), 64'h1234);
    idle(1'b1);

    // Flush priority over a pending accept, outputs not consumed
    cycle(1'b1, 2'b11, 10'h21, 64'h1, 1'b0, 1'b0);
    cycle(1'b1, 2'b11, 10'h42, 64'h2, 1'b0, 1'b0);
    cycle(1'b1, 2'b11, 10'h63, 64'h3, 1'b1, 1'b0);
    chk("fl_occupancy", 64'(bus.occupancy), 64'h0);
    chk("fl_out_valid", 64'(bus.out_valid), 64'h0);
    chk("fl_in_ready", 64'(bus.in_ready), 64'h1);
    idle(1'b1);

    // Flush with out_ready: head counts as consumed, buffer still empties
    cycle(1'b1, 2'b10, 10'h84, 64'h4 << 32, 1'b0, 1'b0);
    cycle(1'b1, 2'b11, 10'hA5, 64'h5, 1'b0, 1'b0);
    cycle(1'b0, 2'b00, 10'h0, 64'h0, 1'b1, 1'b1);
    idle(1'b1);

    // Simultaneous accept and drain with skid empty
    cycle(1'b1, 2'b11, 10'h0C6, 64'h66, 1'b0, 1'b0);
    cycle(1'b1, 2'b11, 10'h0E7, 64'h77, 1'b0, 1'b1);
    chk("ad_occupancy", 64'(bus.occupancy), 64'h1);
    chk("ad_data", bus.out_write_data, 64'h77);
    idle(1'b1);

    // Reset mid-operation with occupancy 2: outputs idle before any edge
    cycle(1'b1, 2'b11, 10'h108, 64'h88, 1'b0, 1'b0);
    cycle(1'b1, 2'b11, 10'h129, 64'h99, 1'b0, 1'b0);
    reset = 1'b0;
    held  = 0;
    exp_q.delete();
    #1;
    chk("mr_out_valid", 64'(bus.out_valid), 64'h0);
    chk("mr_out_en", 64'(bus.out_write_enable), 64'h0);
    chk("mr_out_addr", 64'(bus.out_write_addr), 64'(IDLE_ADDR));
    chk("mr_in_ready", 64'(bus.in_ready), 64'h1);
    chk("mr_occupancy", 64'(bus.occupancy), 64'h0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    cycle(1'b1, 2'b11, 10'h14A, 64'hAA, 1'b0, 1'b0);
    chk("rel_accept", 64'(bus.occupancy), 64'h1);
    idle(1'b1);

    // Randomised traffic
    for (int n = 0; n < 3000; n++)
      cycle(($urandom % 4) != 0, 2'($urandom), 10'($urandom), {$urandom, $urandom},
            ($urandom % 32) == 0, ($urandom % 3) != 0);
    repeat (3) idle(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
